// File: rtl/sig_debounce.sv
// Debouncer for one asynchronous, possibly bouncy input: synchroniser, counter-qualified
// stability FSM, and a saturating count of rejected transitions.
module sig_debounce #(
   parameter int SYNC_STAGES   = 2,
   parameter int STABLE_CYCLES = 16,
   parameter int GLITCH_W      = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                sig_raw,
   input  logic                clr_glitch,
   output logic                sig_clean,
   output logic                settling,
   output logic [GLITCH_W-1:0] glitch_cnt
);

   localparam int CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

   // Bit 1 is the accepted level, bit 0 marks qualification, so outputs come straight off flops.
   typedef enum logic [1:0] {
      LOW   = 2'b00,
      CHK_H = 2'b01,
      HIGH  = 2'b10,
      CHK_L = 2'b11
   } state_t;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   sig_s;
   state_t                 state;
   logic [CNT_W-1:0]       cnt;
   logic                   reject;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync_q <= '0;
      else        sync_q <= {sync_q[SYNC_STAGES-2:0], sig_raw};
   end

   assign sig_s  = sync_q[SYNC_STAGES-1];
   assign reject = ((state == CHK_H) && !sig_s) || ((state == CHK_L) && sig_s);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= LOW;
         cnt   <= '0;
      end else begin
         case (state)
            LOW: if (sig_s) begin
               state <= CHK_H;
               cnt   <= '0;
            end
            CHK_H: begin
               if (!sig_s)               state <= LOW;
               else if (cnt == CNT_LAST) state <= HIGH;
               else                      cnt   <= cnt + CNT_W'(1);
            end
            HIGH: if (!sig_s) begin
               state <= CHK_L;
               cnt   <= '0;
            end
            CHK_L: begin
               if (sig_s)                state <= HIGH;
               else if (cnt == CNT_LAST) state <= LOW;
               else                      cnt   <= cnt + CNT_W'(1);
            end
            default: state <= LOW;
         endcase
      end
   end

   // Clear takes priority over a coincident reject; the count sticks at all-ones.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                            glitch_cnt <= '0;
      else if (clr_glitch)                   glitch_cnt <= '0;
      else if (reject && (glitch_cnt != '1)) glitch_cnt <= glitch_cnt + GLITCH_W'(1);
   end

   assign sig_clean = state[1];
   assign settling  = state[0];

endmodule

// File: tb/tb_sig_debounce.sv
// Directed bench for sig_debounce: hand-timed sequences plus a table of level/hold records.
module tb_sig_debounce;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       sig_raw, clr_glitch;
   logic       sig_clean, settling;
   logic [7:0] glitch_cnt;
   logic       raw_s, clr_s;
   logic       clean_s, settling_s;
   logic [1:0] glitch_s;

   int n_vec = 0;
   int n_err = 0;
   int edge_pulses = 0;
   logic prev_clean = 1'b0;

   always #5 clk = ~clk;

   sig_debounce dut (
      .clk(clk), .rst_n(rst_n), .sig_raw(sig_raw), .clr_glitch(clr_glitch),
      .sig_clean(sig_clean), .settling(settling), .glitch_cnt(glitch_cnt)
   );

   sig_debounce #(.GLITCH_W(2)) dut_s (
      .clk(clk), .rst_n(rst_n), .sig_raw(raw_s), .clr_glitch(clr_s),
      .sig_clean(clean_s), .settling(settling_s), .glitch_cnt(glitch_s)
   );

   typedef struct {
      logic raw;
      logic clr;
      int   cycles;
      logic exp_clean;
      logic exp_settling;
      int   exp_glitch;
   } vec_t;

   vec_t tbl[10];

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // One rising edge, then settle; also acts as the downstream any-edge detector.
   task automatic step();
      @(posedge clk);
      #1;
      if (sig_clean !== prev_clean) edge_pulses++;
      prev_clean = sig_clean;
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      int hi_cycles;
      int exp_rej;
      int pw[10];
      int gw[10];

      rst_n = 1'b0; sig_raw = 1'b1; clr_glitch = 1'b0; raw_s = 1'b0; clr_s = 1'b0;

      // Reset and rise
      steps(3);
      chk("reset_clean", int'(sig_clean), 0);
      chk("reset_settling", int'(settling), 0);
      chk("reset_glitch", int'(glitch_cnt), 0);
      rst_n = 1'b1;
      for (int k = 0; k <= 18; k++) begin
         step();
         if (k == 1)  chk("rise_settle_e1", int'(settling), 0);
         if (k == 2)  chk("rise_settle_e2", int'(settling), 1);
         if (k == 17) chk("rise_clean_e17", int'(sig_clean), 0);
         if (k == 18) begin
            chk("rise_clean_e18", int'(sig_clean), 1);
            chk("rise_settle_e18", int'(settling), 0);
            chk("rise_glitch", int'(glitch_cnt), 0);
         end
      end
      steps(2);

      // Falling glitch of 15 cycles, then a real fall
      sig_raw = 1'b0;
      steps(15);
      chk("fall_g_settle", int'(settling), 1);
      sig_raw = 1'b1;
      steps(2);
      chk("fall_g_glitch_pre", int'(glitch_cnt), 0);
      step();
      chk("fall_g_glitch", int'(glitch_cnt), 1);
      chk("fall_g_settle_off", int'(settling), 0);
      chk("fall_g_clean", int'(sig_clean), 1);
      steps(5);
      sig_raw = 1'b0;
      steps(18);
      chk("fall_clean_e17", int'(sig_clean), 1);
      step();
      chk("fall_clean_e18", int'(sig_clean), 0);
      chk("fall_settle_e18", int'(settling), 0);
      steps(3);

      // Rising glitch of 5 cycles
      hi_cycles = 0;
      for (int k = 0; k < 10; k++) begin
         sig_raw = (k < 5);
         step();
         if (settling) hi_cycles++;
         if (k == 1) chk("rg_settle_e1", int'(settling), 0);
         if (k == 2) chk("rg_settle_e2", int'(settling), 1);
         if (k == 6) chk("rg_glitch_e6", int'(glitch_cnt), 1);
         if (k == 7) begin
            chk("rg_glitch_e7", int'(glitch_cnt), 2);
            chk("rg_settle_e7", int'(settling), 0);
         end
      end
      chk("rg_settle_cycles", hi_cycles, 5);
      chk("rg_clean", int'(sig_clean), 0);

      // Level/hold table, starting in LOW with glitch_cnt = 2
      tbl[0] = '{1'b0, 1'b0,  4, 1'b0, 1'b0, 2};
      tbl[1] = '{1'b1, 1'b0,  2, 1'b0, 1'b0, 2};
      tbl[2] = '{1'b1, 1'b0,  1, 1'b0, 1'b1, 2};
      tbl[3] = '{1'b1, 1'b0, 16, 1'b1, 1'b0, 2};
      tbl[4] = '{1'b0, 1'b0,  3, 1'b1, 1'b1, 2};
      tbl[5] = '{1'b1, 1'b0,  2, 1'b1, 1'b1, 2};
      tbl[6] = '{1'b1, 1'b0,  1, 1'b1, 1'b0, 3};
      tbl[7] = '{1'b1, 1'b0,  3, 1'b1, 1'b0, 3};
      tbl[8] = '{1'b1, 1'b1,  1, 1'b1, 1'b0, 0};
      tbl[9] = '{1'b1, 1'b0,  2, 1'b1, 1'b0, 0};
      for (int i = 0; i < 10; i++) begin
         sig_raw    = tbl[i].raw;
         clr_glitch = tbl[i].clr;
         steps(tbl[i].cycles);
         chk($sformatf("tbl%0d_clean", i), int'(sig_clean), int'(tbl[i].exp_clean));
         chk($sformatf("tbl%0d_settle", i), int'(settling), int'(tbl[i].exp_settling));
         chk($sformatf("tbl%0d_glitch", i), int'(glitch_cnt), tbl[i].exp_glitch);
      end
      clr_glitch = 1'b0;

      // Saturation and clear priority on the 2-bit instance
      for (int g = 0; g < 5; g++) begin
         raw_s = 1'b1; steps(3);
         raw_s = 1'b0; steps(5);
         chk($sformatf("sat_g%0d", g), int'(glitch_s), (g + 1 > 3) ? 3 : g + 1);
      end
      raw_s = 1'b1; steps(3);
      raw_s = 1'b0; steps(2);
      chk("sat_pre_clr", int'(glitch_s), 3);
      clr_s = 1'b1;
      step();
      clr_s = 1'b0;
      chk("sat_clr_wins", int'(glitch_s), 0);
      chk("sat_settle_off", int'(settling_s), 0);

      // Reset mid-qualification
      sig_raw = 1'b0; steps(20);
      sig_raw = 1'b1; steps(13);
      chk("mid_settle", int'(settling), 1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_settle", int'(settling), 0);
      chk("mid_rst_clean", int'(sig_clean), 0);
      steps(2);
      rst_n = 1'b1;
      for (int k = 0; k <= 18; k++) begin
         step();
         if (k == 17) chk("mid_clean_e17", int'(sig_clean), 0);
         if (k == 18) chk("mid_clean_e18", int'(sig_clean), 1);
      end

      // Bounce burst into any-edge detector
      sig_raw = 1'b0; steps(20);
      chk("bnc_start_low", int'(sig_clean), 0);
      pw = '{1, 3, 2, 1, 2, 3, 1, 1, 2, 3};
      gw = '{1, 2, 1, 3, 1, 1, 2, 1, 2, 7};
      exp_rej = 0;
      edge_pulses = 0;
      for (int p = 0; p < 10; p++) begin
         if (pw[p] >= 1 && pw[p] <= 16) exp_rej++;
         sig_raw = 1'b1; steps(pw[p]);
         sig_raw = 1'b0; steps(gw[p]);
      end
      chk("bnc_no_edge", edge_pulses, 0);
      sig_raw = 1'b1; steps(25);
      chk("bnc_edges", edge_pulses, 1);
      chk("bnc_clean", int'(sig_clean), 1);
      chk("bnc_glitch", int'(glitch_cnt), exp_rej);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
